// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue for the ALU stage. It captures CDB results
// for pending operands and presents the oldest fully ready operation each cycle.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int OP_W  = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [OP_W-1:0]              enq_aluop,
    input  logic [31:0]                  enq_rega,
    input  logic [31:0]                  enq_regb,
    input  logic                         enq_rega_rdy,
    input  logic                         enq_regb_rdy,
    input  logic [TAG_W-1:0]             enq_rega_tag,
    input  logic [TAG_W-1:0]             enq_regb_tag,
    input  logic [31:0]                  enq_imm,
    input  logic                         enq_use_imm,
    input  logic [TAG_W-1:0]             enq_dest_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_aluop,
    output logic [31:0]                  iss_rega,
    output logic [31:0]                  iss_regb,
    output logic [31:0]                  iss_imm,
    output logic                         iss_use_imm,
    output logic [TAG_W-1:0]             iss_dest_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   aluop;
        logic [31:0]       rega;
        logic              rega_rdy;
        logic [TAG_W-1:0]  rega_tag;
        logic [31:0]       regb;
        logic              regb_rdy;
        logic [TAG_W-1:0]  regb_tag;
        logic [31:0]       imm;
        logic              use_imm;
        logic [TAG_W-1:0]  dest_tag;
    } entry_t;

    entry_t             r_q [DEPTH];
    logic [CNT_W-1:0]   r_count;

    entry_t             w_ext [DEPTH+1];
    entry_t             w_nq  [DEPTH];
    entry_t             w_new;
    entry_t             w_cur;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic               w_issue;
    logic               w_enq;
    logic [CNT_W-1:0]   w_pos;
    logic [CNT_W-1:0]   w_count_n;

    // Scan from the youngest slot down so the oldest ready entry wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].rega_rdy && r_q[i].regb_rdy) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
    end

    assign enq_ready = (r_count < CNT_W'(DEPTH));
    assign w_issue   = w_found && iss_ready;
    assign w_enq     = enq_valid && enq_ready && !flush;
    assign w_pos     = r_count - CNT_W'(w_issue);
    assign w_count_n = flush ? '0 : (r_count + CNT_W'(w_enq) - CNT_W'(w_issue));

    // Incoming entry, with same-cycle CDB capture for pending operands.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.aluop    = enq_aluop;
        w_new.rega     = enq_rega;
        w_new.rega_rdy = enq_rega_rdy;
        w_new.rega_tag = enq_rega_tag;
        w_new.regb     = enq_regb;
        w_new.regb_rdy = enq_regb_rdy || enq_use_imm;
        w_new.regb_tag = enq_regb_tag;
        w_new.imm      = enq_imm;
        w_new.use_imm  = enq_use_imm;
        w_new.dest_tag = enq_dest_tag;
        if (cdb_valid && !w_new.rega_rdy && (cdb_tag == w_new.rega_tag)) begin
            w_new.rega     = cdb_data;
            w_new.rega_rdy = 1'b1;
        end
        if (cdb_valid && !w_new.regb_rdy && (cdb_tag == w_new.regb_tag)) begin
            w_new.regb     = cdb_data;
            w_new.regb_rdy = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = r_q[i];
        end
        w_ext[DEPTH] = '0;
    end

    // Collapse over the issued slot, then wake up, then drop in the new entry.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cur = (w_issue && (i >= int'(w_sel))) ? w_ext[i+1] : w_ext[i];
            if (w_cur.valid && cdb_valid && !w_cur.rega_rdy && (cdb_tag == w_cur.rega_tag)) begin
                w_cur.rega     = cdb_data;
                w_cur.rega_rdy = 1'b1;
            end
            if (w_cur.valid && cdb_valid && !w_cur.regb_rdy && (cdb_tag == w_cur.regb_tag)) begin
                w_cur.regb     = cdb_data;
                w_cur.regb_rdy = 1'b1;
            end
            if (w_enq && (w_pos == CNT_W'(i))) begin
                w_cur = w_new;
            end
            if (flush) begin
                w_cur = '0;
            end
            w_nq[i] = w_cur;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nq[i];
            end
            r_count <= w_count_n;
        end
    end

    assign iss_valid    = w_found;
    assign iss_aluop    = w_found ? r_q[w_sel].aluop    : '0;
    assign iss_rega     = w_found ? r_q[w_sel].rega     : '0;
    assign iss_regb     = w_found ? r_q[w_sel].regb     : '0;
    assign iss_imm      = w_found ? r_q[w_sel].imm      : '0;
    assign iss_use_imm  = w_found ? r_q[w_sel].use_imm  : 1'b0;
    assign iss_dest_tag = w_found ? r_q[w_sel].dest_tag : '0;
    assign count        = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios with a scoreboard of expected
// issued operations, popped whenever the ALU accepts one.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int OP_W  = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [OP_W-1:0]   enq_aluop = '0;
    logic [31:0]       enq_rega = '0;
    logic [31:0]       enq_regb = '0;
    logic              enq_rega_rdy = 1'b0;
    logic              enq_regb_rdy = 1'b0;
    logic [TAG_W-1:0]  enq_rega_tag = '0;
    logic [TAG_W-1:0]  enq_regb_tag = '0;
    logic [31:0]       enq_imm = '0;
    logic              enq_use_imm = 1'b0;
    logic [TAG_W-1:0]  enq_dest_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [31:0]       cdb_data = '0;
    logic              iss_valid;
    logic              iss_ready = 1'b0;
    logic [OP_W-1:0]   iss_aluop;
    logic [31:0]       iss_rega;
    logic [31:0]       iss_regb;
    logic [31:0]       iss_imm;
    logic              iss_use_imm;
    logic [TAG_W-1:0]  iss_dest_tag;
    logic [2:0]        count;

    logic [127:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_aluop(enq_aluop),
        .enq_rega(enq_rega), .enq_regb(enq_regb),
        .enq_rega_rdy(enq_rega_rdy), .enq_regb_rdy(enq_regb_rdy),
        .enq_rega_tag(enq_rega_tag), .enq_regb_tag(enq_regb_tag),
        .enq_imm(enq_imm), .enq_use_imm(enq_use_imm), .enq_dest_tag(enq_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_aluop(iss_aluop),
        .iss_rega(iss_rega), .iss_regb(iss_regb), .iss_imm(iss_imm),
        .iss_use_imm(iss_use_imm), .iss_dest_tag(iss_dest_tag), .count(count)
    );

    // Clock
    always #5 clock = ~clock;

    function automatic logic [127:0] pk(input logic [OP_W-1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm,
                                        input logic use_imm, input logic [TAG_W-1:0] dest);
        return {20'd0, op, a, b, imm, use_imm, dest};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_enq(input logic [OP_W-1:0] op, input logic [31:0] a, input logic a_rdy,
                             input logic [TAG_W-1:0] a_tag, input logic [31:0] b, input logic b_rdy,
                             input logic [TAG_W-1:0] b_tag, input logic [31:0] imm,
                             input logic use_imm, input logic [TAG_W-1:0] dest);
        enq_valid    = 1'b1;
        enq_aluop    = op;
        enq_rega     = a;
        enq_rega_rdy = a_rdy;
        enq_rega_tag = a_tag;
        enq_regb     = b;
        enq_regb_rdy = b_rdy;
        enq_regb_tag = b_tag;
        enq_imm      = imm;
        enq_use_imm  = use_imm;
        enq_dest_tag = dest;
    endtask

    task automatic drive_cdb(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data);
        cdb_valid = v;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // Scoreboard: every accepted issue must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got dest %0h with no expected entry", iss_dest_tag);
            end else begin
                check_eq("issue", pk(iss_aluop, iss_rega, iss_regb, iss_imm, iss_use_imm, iss_dest_tag),
                         exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rnd_a;
        logic [31:0] rnd_b;
        int budget;

        repeat (3) step();
        reset = 1'b1;
        step();
        check_eq("init_count", count, 0);
        check_eq("init_enq_ready", enq_ready, 1);
        check_eq("init_iss_valid", iss_valid, 0);

        // Ready op
        iss_ready = 1'b1;
        drive_enq(5'd1, 32'd5, 1'b1, '0, 32'd7, 1'b1, '0, 32'd0, 1'b0, 6'd1);
        exp_q.push_back(pk(5'd1, 32'd5, 32'd7, 32'd0, 1'b0, 6'd1));
        step();
        enq_valid = 1'b0;
        check_eq("ready_iss_valid", iss_valid, 1);
        check_eq("ready_rega", iss_rega, 5);
        check_eq("ready_regb", iss_regb, 7);
        check_eq("ready_count", count, 1);
        step();
        check_eq("ready_count_after", count, 0);
        check_eq("ready_iss_valid_after", iss_valid, 0);

        // Immediate form: regb treated as ready despite a pending tag
        rnd_a = $urandom_range(1, 1000);
        drive_enq(5'd2, rnd_a, 1'b1, '0, 32'd0, 1'b0, 6'd7, 32'hFFFF_FFF0, 1'b1, 6'd2);
        exp_q.push_back(pk(5'd2, rnd_a, 32'd0, 32'hFFFF_FFF0, 1'b1, 6'd2));
        step();
        enq_valid = 1'b0;
        check_eq("imm_iss_valid", iss_valid, 1);
        step();

        // Dependent op, broadcast two cycles later
        drive_enq(5'd3, 32'hDEAD, 1'b0, 6'd3, 32'd2, 1'b1, '0, 32'd0, 1'b0, 6'd4);
        exp_q.push_back(pk(5'd3, 32'h10, 32'd2, 32'd0, 1'b0, 6'd4));
        step();
        enq_valid = 1'b0;
        check_eq("dep_wait0", iss_valid, 0);
        step();
        check_eq("dep_wait1", iss_valid, 0);
        drive_cdb(1'b1, 6'd3, 32'h10);
        step();
        drive_cdb(1'b0, '0, '0);
        check_eq("dep_wake_valid", iss_valid, 1);
        check_eq("dep_wake_rega", iss_rega, 32'h10);
        step();
        check_eq("dep_count", count, 0);

        // Insertion bypass: broadcast in the enqueue cycle
        drive_enq(5'd4, 32'hBEEF, 1'b0, 6'd3, 32'd9, 1'b1, '0, 32'd0, 1'b0, 6'd5);
        drive_cdb(1'b1, 6'd3, 32'h20);
        exp_q.push_back(pk(5'd4, 32'h20, 32'd9, 32'd0, 1'b0, 6'd5));
        step();
        enq_valid = 1'b0;
        drive_cdb(1'b0, '0, '0);
        check_eq("byp_valid", iss_valid, 1);
        check_eq("byp_rega", iss_rega, 32'h20);
        step();

        // Age order: A waits on tag 9, B and C ready
        iss_ready = 1'b0;
        drive_enq(5'd5, 32'd0, 1'b0, 6'd9, 32'h55, 1'b1, '0, 32'd0, 1'b0, 6'd10);
        step();
        rnd_a = $urandom_range(0, 32'hFFFF);
        drive_enq(5'd6, rnd_a, 1'b1, '0, 32'd1, 1'b1, '0, 32'd0, 1'b0, 6'd11);
        exp_q.push_back(pk(5'd6, rnd_a, 32'd1, 32'd0, 1'b0, 6'd11));
        step();
        rnd_b = $urandom_range(0, 32'hFFFF);
        drive_enq(5'd7, rnd_b, 1'b1, '0, 32'd2, 1'b1, '0, 32'd0, 1'b0, 6'd12);
        exp_q.push_back(pk(5'd7, rnd_b, 32'd2, 32'd0, 1'b0, 6'd12));
        step();
        enq_valid = 1'b0;
        check_eq("age_count", count, 3);
        check_eq("age_first_sel", iss_dest_tag, 11);
        iss_ready = 1'b1;
        step();
        check_eq("age_second_sel", iss_dest_tag, 12);
        step();
        check_eq("age_a_waiting", iss_valid, 0);
        check_eq("age_a_count", count, 1);
        drive_cdb(1'b1, 6'd9, 32'h99);
        exp_q.push_back(pk(5'd5, 32'h99, 32'h55, 32'd0, 1'b0, 6'd10));
        step();
        drive_cdb(1'b0, '0, '0);
        check_eq("age_a_rega", iss_rega, 32'h99);
        step();
        check_eq("age_count_end", count, 0);

        // Full and simultaneous issue/enqueue
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rnd_a = $urandom;
            drive_enq(5'(8 + i), rnd_a, 1'b1, '0, 32'(i), 1'b1, '0, 32'd0, 1'b0, 6'(20 + i));
            exp_q.push_back(pk(5'(8 + i), rnd_a, 32'(i), 32'd0, 1'b0, 6'(20 + i)));
            step();
        end
        enq_valid = 1'b0;
        check_eq("full_count", count, 4);
        check_eq("full_enq_ready", enq_ready, 0);
        drive_enq(5'd15, 32'h4444, 1'b1, '0, 32'h4, 1'b1, '0, 32'd0, 1'b0, 6'd24);
        exp_q.push_back(pk(5'd15, 32'h4444, 32'h4, 32'd0, 1'b0, 6'd24));
        iss_ready = 1'b1;
        step();
        check_eq("full_one_issue", count, 3);
        check_eq("full_ready_back", enq_ready, 1);
        step();
        enq_valid = 1'b0;
        check_eq("full_enq_and_issue", count, 3);
        budget = 20;
        while (count != 0 && budget > 0) begin
            step();
            budget--;
        end
        check_eq("full_drained", count, 0);

        // Flush with concurrent enqueue and issue
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(5'd16, 32'(100 + i), 1'b1, '0, 32'd0, 1'b1, '0, 32'd0, 1'b0, 6'(30 + i));
            step();
        end
        enq_valid = 1'b0;
        check_eq("flush_pre_count", count, 3);
        exp_q.push_back(pk(5'd16, 32'd100, 32'd0, 32'd0, 1'b0, 6'd30));
        drive_enq(5'd17, 32'h77, 1'b1, '0, 32'd0, 1'b1, '0, 32'd0, 1'b0, 6'd33);
        flush = 1'b1;
        iss_ready = 1'b1;
        step();
        flush = 1'b0;
        enq_valid = 1'b0;
        check_eq("flush_count", count, 0);
        check_eq("flush_iss_valid", iss_valid, 0);
        repeat (3) begin
            step();
            check_eq("flush_no_issue", iss_valid, 0);
        end

        // Asynchronous reset mid-run with entries held
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(5'd18, 32'(200 + i), 1'b1, '0, 32'd3, 1'b1, '0, 32'd0, 1'b0, 6'(40 + i));
            step();
        end
        enq_valid = 1'b0;
        check_eq("rst_pre_count", count, 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_iss_valid", iss_valid, 0);
        check_eq("rst_enq_ready", enq_ready, 1);
        check_eq("rst_iss_rega", iss_rega, 0);
        check_eq("rst_iss_dest", iss_dest_tag, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check_eq("rst_post_count", count, 0);
        check_eq("rst_post_iss_valid", iss_valid, 0);

        check_eq("exp_q_drained", 128'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
